peripheral_gpio_irq_apb4: RTL
=============================

PERIPHERAL_GPIO_IRQ_APB4 -- requirements
Module: peripheral_gpio_irq_apb4

Interface
REQ-001 SHALL have parameter PADDR_SIZE, default 10, APB address width.
REQ-002 SHALL have parameter PDATA_SIZE, default 32, APB data width (multiple of 8).
REQ-003 SHALL have parameter GPIO_WIDTH, default 16, pin count (1..PDATA_SIZE).
REQ-004 SHALL have parameter SYNC_DEPTH, default 3, input synchroniser stages (>=2).
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 PCLK  in  1  sole clock, all state on rising edge.
REQ-007 PRESET  in  1  synchronous active-high reset.
REQ-008 PSEL, PENABLE, PWRITE  in  1 each  APB4 control.
REQ-009 PSTRB  in  PDATA_SIZE/8  write byte-lane enables.
REQ-010 PADDR  in  PADDR_SIZE  byte address; PADDR[4:2] selects register, other bits ignored.
REQ-011 PWDATA in / PRDATA out  PDATA_SIZE  write/read data.
REQ-012 PREADY  out  1  tied 1 (zero wait states).
REQ-013 PSLVERR  out  1  error response.
REQ-014 gpio_i in / gpio_o out / gpio_oe out  GPIO_WIDTH  pin input, output value, output enable.
REQ-015 irq_o  out  1  registered level interrupt.

Function
REQ-016 Register map (word offset): 0x00 DIR (RW, 1=output), 0x04 OUT (RW), 0x08 IN (RO), 0x0C IE (RW), 0x10 RISE (RW), 0x14 FALL (RW), 0x18 STATUS (RW1C), 0x1C TOGGLE (WO, read 0).
REQ-017 Write commits on the rising edge where PSEL&PENABLE&PWRITE, per byte lane with PSTRB set; bits above GPIO_WIDTH ignored on write, read 0.
REQ-018 PRDATA driven combinationally during PSEL&~PWRITE; 0 otherwise.
REQ-019 PSLVERR=1 during access phase for write to IN, read of TOGGLE excluded (returns 0, no error); write to IN has no effect.
REQ-020 TOGGLE write: OUT <= OUT ^ (PWDATA masked by PSTRB); same-cycle priority irrelevant as only one register addressed per access.
REQ-021 gpio_o = OUT; gpio_oe = DIR; both registered, no combinational path from APB.
REQ-022 Synchroniser: s[0]<=gpio_i, s[n]<=s[n-1]; IN = s[SYNC_DEPTH-1]; prev<=IN each cycle.
REQ-023 event[b] = (RISE[b] & IN[b] & ~prev[b]) | (FALL[b] & ~IN[b] & prev[b]); RISE&FALL both = any edge; neither = no event.
REQ-024 STATUS[b] <= event[b] | (STATUS[b] & ~w1c[b]); set wins over simultaneous W1C of same bit.
REQ-025 STATUS latches regardless of IE; irq_o <= |(STATUS & IE) registered.
REQ-026 Latency: gpio_i stable before edge 0 -> IN updated after edge SYNC_DEPTH-1, STATUS after edge SYNC_DEPTH, irq_o after edge SYNC_DEPTH+1.
REQ-027 Clearing IE or STATUS deasserts irq_o one edge after the write edge.
REQ-028 Pulses shorter than one PCLK period are not guaranteed to be captured.

Reset
REQ-029 PRESET high at a rising edge: DIR, OUT, IE, RISE, FALL, STATUS, sync stages, prev, irq_o all 0; gpio_o=0, gpio_oe=0.
REQ-030 Reset overrides any concurrent APB write; no event generated in reset cycle or the first cycle after (prev and IN both 0).
REQ-031 PREADY=1 and PSLVERR=0 hold during reset.

Verification
REQ-032 Reset, read all offsets -> all return 0, PSLVERR=0; gpio_oe=0.
REQ-033 Write DIR=0x00FF, OUT=0x00A5 with PSTRB=0b0001 -> gpio_oe=0x00FF, gpio_o=0x00A5; then TOGGLE=0x000F -> gpio_o=0x00AA.
REQ-034 SYNC_DEPTH=3, RISE=0x0001, IE=0x0001, gpio_i[0] 0->1 before edge 0 -> IN[0]=1 after edge 2, STATUS=0x0001 after edge 3, irq_o=1 after edge 4; W1C 0x0001 -> irq_o=0 next edge.
REQ-035 FALL=0x0002, IE=0 -> falling edge on pin 1 sets STATUS[1], irq_o stays 0; IE=0x0002 write -> irq_o=1 next edge.
REQ-036 W1C STATUS[0] in same cycle as new rising event on pin 0 -> STATUS[0] remains 1.
REQ-037 Write 0x5 to IN -> PSLVERR=1 in access phase, IN unchanged; PRESET asserted mid-transaction -> all registers 0 next edge.

Source files
------------

// File: rtl/peripheral_gpio_irq_apb4.sv
// APB4 GPIO block: direction/output registers, synchronised inputs, and
// per-pin rise/fall edge detection into a sticky status with a level interrupt.
module peripheral_gpio_irq_apb4 #(
  parameter int PADDR_SIZE = 10,
  parameter int PDATA_SIZE = 32,
  parameter int GPIO_WIDTH = 16,
  parameter int SYNC_DEPTH = 3
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    PSEL,
  input  logic                    PENABLE,
  input  logic                    PWRITE,
  input  logic [PDATA_SIZE/8-1:0] PSTRB,
  input  logic [PADDR_SIZE-1:0]   PADDR,
  input  logic [PDATA_SIZE-1:0]   PWDATA,
  output logic [PDATA_SIZE-1:0]   PRDATA,
  output logic                    PREADY,
  output logic                    PSLVERR,
  input  logic [GPIO_WIDTH-1:0]   gpio_i,
  output logic [GPIO_WIDTH-1:0]   gpio_o,
  output logic [GPIO_WIDTH-1:0]   gpio_oe,
  output logic                    irq_o
);

  localparam int NLANE = PDATA_SIZE / 8;

  localparam logic [2:0] A_DIR    = 3'd0;
  localparam logic [2:0] A_OUT    = 3'd1;
  localparam logic [2:0] A_IN     = 3'd2;
  localparam logic [2:0] A_IE     = 3'd3;
  localparam logic [2:0] A_RISE   = 3'd4;
  localparam logic [2:0] A_FALL   = 3'd5;
  localparam logic [2:0] A_STATUS = 3'd6;
  localparam logic [2:0] A_TOGGLE = 3'd7;

  function automatic logic [PDATA_SIZE-1:0] lane_mask(input logic [NLANE-1:0] strb);
    logic [PDATA_SIZE-1:0] m;
    m = '0;
    for (int i = 0; i < NLANE; i++) m[i*8 +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [PDATA_SIZE-1:0] zext(input logic [GPIO_WIDTH-1:0] v);
    logic [PDATA_SIZE-1:0] r;
    r = '0;
    r[GPIO_WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old_v,
                                                  input logic [GPIO_WIDTH-1:0] new_v,
                                                  input logic [GPIO_WIDTH-1:0] mask);
    return (old_v & ~mask) | (new_v & mask);
  endfunction

  logic [GPIO_WIDTH-1:0] dir_q, dir_d;
  logic [GPIO_WIDTH-1:0] out_q, out_d;
  logic [GPIO_WIDTH-1:0] ie_q, ie_d;
  logic [GPIO_WIDTH-1:0] rise_q, rise_d;
  logic [GPIO_WIDTH-1:0] fall_q, fall_d;
  logic [GPIO_WIDTH-1:0] status_q, status_d;
  logic [GPIO_WIDTH-1:0] prev_q;
  logic [GPIO_WIDTH-1:0] sync_q [SYNC_DEPTH];
  logic                  irq_q, irq_d;

  logic                  wr_en, rd_en;
  logic [2:0]            addr;
  logic [PDATA_SIZE-1:0] strb_mask;
  logic [GPIO_WIDTH-1:0] wmask, wdata, w1c, in_w, evt;
  logic                  unused_bits;

  assign wr_en     = PSEL & PENABLE & PWRITE;
  assign rd_en     = PSEL & ~PWRITE;
  assign addr      = PADDR[4:2];
  assign strb_mask = lane_mask(PSTRB);
  assign wmask     = strb_mask[GPIO_WIDTH-1:0];
  assign wdata     = PWDATA[GPIO_WIDTH-1:0];
  assign in_w      = sync_q[SYNC_DEPTH-1];
  // Address bits outside [4:2] and data bits above the pin count are don't-care.
  assign unused_bits = ^{PADDR, PWDATA};

  always_comb begin
    dir_d  = dir_q;
    out_d  = out_q;
    ie_d   = ie_q;
    rise_d = rise_q;
    fall_d = fall_q;
    w1c    = '0;
    if (wr_en) begin
      case (addr)
        A_DIR:    dir_d  = merge(dir_q, wdata, wmask);
        A_OUT:    out_d  = merge(out_q, wdata, wmask);
        A_IE:     ie_d   = merge(ie_q, wdata, wmask);
        A_RISE:   rise_d = merge(rise_q, wdata, wmask);
        A_FALL:   fall_d = merge(fall_q, wdata, wmask);
        A_STATUS: w1c    = wdata & wmask;
        A_TOGGLE: out_d  = out_q ^ (wdata & wmask);
        default:  ;
      endcase
    end
    evt      = (rise_q & in_w & ~prev_q) | (fall_q & ~in_w & prev_q);
    // A new event wins over a simultaneous write-one-to-clear of the same bit.
    status_d = evt | (status_q & ~w1c);
    irq_d    = |(status_q & ie_q);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      dir_q    <= '0;
      out_q    <= '0;
      ie_q     <= '0;
      rise_q   <= '0;
      fall_q   <= '0;
      status_q <= '0;
      prev_q   <= '0;
      irq_q    <= 1'b0;
      for (int i = 0; i < SYNC_DEPTH; i++) sync_q[i] <= '0;
    end else begin
      dir_q    <= dir_d;
      out_q    <= out_d;
      ie_q     <= ie_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      status_q <= status_d;
      prev_q   <= in_w;
      irq_q    <= irq_d;
      sync_q[0] <= gpio_i;
      for (int i = 1; i < SYNC_DEPTH; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  always_comb begin
    PRDATA = '0;
    if (rd_en) begin
      case (addr)
        A_DIR:    PRDATA = zext(dir_q);
        A_OUT:    PRDATA = zext(out_q);
        A_IN:     PRDATA = zext(in_w);
        A_IE:     PRDATA = zext(ie_q);
        A_RISE:   PRDATA = zext(rise_q);
        A_FALL:   PRDATA = zext(fall_q);
        A_STATUS: PRDATA = zext(status_q);
        default:  PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = 1'b1;
  assign PSLVERR = ~PRESET & wr_en & (addr == A_IN);
  assign gpio_o  = out_q;
  assign gpio_oe = dir_q;
  assign irq_o   = irq_q;

endmodule
